// File: rtl/control_flow_sequencer_pkg.sv
// control_flow_sequencer_pkg: widths, op encodings, frame types and frame field layout.
package control_flow_sequencer_pkg;
  localparam int CS_W = 27;
  localparam int PC_W = 18;
  localparam int TAG_W = 6;
  localparam int LBL_W = 8;
  localparam int TYPE_HI = 26;
  localparam int TYPE_LO = 25;
  localparam int RETU_B = 24;
  localparam int TAG_HI = 23;
  localparam int TAG_LO = 18;
  localparam int EXTRA_HI = 17;
  localparam int EXTRA_LO = 0;
  typedef enum logic [3:0] {
    OP_OTHER  = 4'd0,
    OP_BLOCK  = 4'd1,
    OP_LOOP   = 4'd2,
    OP_IF     = 4'd3,
    OP_ELSE   = 4'd4,
    OP_END    = 4'd5,
    OP_BR     = 4'd6,
    OP_BR_IF  = 4'd7,
    OP_CALL   = 4'd8,
    OP_RETURN = 4'd9
  } op_e;
  localparam logic [1:0] FT_BLOCK = 2'b00;
  localparam logic [1:0] FT_CALL  = 2'b01;
  localparam logic [1:0] FT_IF    = 2'b10;
  localparam logic [1:0] FT_LOOP  = 2'b11;
  typedef enum logic [1:0] {S_RUN, S_UNWIND, S_DONE} state_e;
  typedef struct packed {
    logic [1:0]       typ;
    logic             retu;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  extra;
  } frame_t;
endpackage

// File: rtl/control_flow_sequencer_frame_pack.sv
// cfs_frame_pack: packs a frame from its fields and splits the stack's top frame back into fields.
module cfs_frame_pack
  import control_flow_sequencer_pkg::*;
(
  input  logic [1:0]       in_type,
  input  logic             in_retu,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [PC_W-1:0]  in_extra,
  output logic [CS_W-1:0]  frame,
  input  logic [CS_W-1:0]  top,
  output frame_t           top_f
);
  assign frame = {in_type, in_retu, in_tag, in_extra};
  assign top_f.typ = top[TYPE_HI:TYPE_LO];
  assign top_f.retu = top[RETU_B];
  assign top_f.tag = top[TAG_HI:TAG_LO];
  assign top_f.extra = top[EXTRA_HI:EXTRA_LO];
endmodule

// File: rtl/control_flow_sequencer.sv
// control_flow_sequencer: WASM structured-control sequencer driving the control stack and fetch redirects.
// Define CFS_STATS_EN to add saturating branch/call/unwind statistics outputs.
module control_flow_sequencer
  import control_flow_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_vld,
  output logic             instr_rdy,
  input  logic [3:0]       instr_op,
  input  logic [PC_W-1:0]  instr_pc,
  input  logic [PC_W-1:0]  end_pc,
  input  logic [PC_W-1:0]  else_pc,
  input  logic             has_else,
  input  logic [PC_W-1:0]  call_pc,
  input  logic [LBL_W-1:0] br_depth,
  input  logic             cond,
  input  logic             blk_retu,
  input  logic [TAG_W-1:0] sp_tag,
  output logic             cs_shift_vld,
  output logic             cs_push,
  output logic             cs_pop,
  output logic             cs_retu,
  output logic             cs_function_call,
  output logic [CS_W-1:0]  cs_push_data,
  input  logic [CS_W-1:0]  cs_top_data,
  input  logic             cs_left_one,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_target,
  output logic             prog_done
`ifdef CFS_STATS_EN
  ,
  output logic [31:0]      stat_br_taken,
  output logic [31:0]      stat_calls,
  output logic [31:0]      stat_unwind_cycles
`endif
);
  state_e state_q, state_d;
  logic [LBL_W-1:0] rem_q, rem_d;
  logic pc_load_q, pc_load_d, prog_done_q, prog_done_d;
  logic [PC_W-1:0] pc_target_q, pc_target_d, pc_inc, new_extra, redir_pc;
  logic [1:0] new_type;
  logic accept, push, pop, retu, fcall, take, resolve, redir;
  frame_t top_f;
  logic unused_top;
  cfs_frame_pack u_pack (
    .in_type (new_type),
    .in_retu (blk_retu),
    .in_tag  (sp_tag),
    .in_extra(new_extra),
    .frame   (cs_push_data),
    .top     (cs_top_data),
    .top_f   (top_f)
  );
  assign unused_top = ^{top_f.retu, top_f.tag};
  assign pc_inc = instr_pc + PC_W'(1);
  assign instr_rdy = (state_q == S_RUN) & ~pc_load_q;
  assign accept = instr_vld & instr_rdy & ~rst;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    prog_done_d = prog_done_q;
    push = 1'b0;
    pop = 1'b0;
    retu = 1'b0;
    fcall = 1'b0;
    take = 1'b0;
    resolve = 1'b0;
    redir = 1'b0;
    redir_pc = top_f.extra;
    new_type = FT_BLOCK;
    new_extra = end_pc;
    if (accept) begin
      case (op_e'(instr_op))
        OP_BLOCK: push = 1'b1;
        OP_LOOP: begin
          push = 1'b1;
          new_type = FT_LOOP;
          new_extra = pc_inc;
        end
        OP_IF: begin
          new_type = FT_IF;
          push = cond | has_else;
          redir = ~cond;
          redir_pc = has_else ? else_pc : end_pc;
        end
        OP_ELSE: begin
          pop = 1'b1;
          redir = 1'b1;
        end
        OP_END: begin
          pop = 1'b1;
          if (top_f.typ == FT_CALL) begin
            redir = ~cs_left_one;
            prog_done_d = prog_done_q | cs_left_one;
            state_d = cs_left_one ? S_DONE : S_RUN;
          end
        end
        OP_BR: take = 1'b1;
        OP_BR_IF: take = cond;
        OP_CALL: begin
          push = 1'b1;
          fcall = 1'b1;
          new_type = FT_CALL;
          new_extra = pc_inc;
          redir = 1'b1;
          redir_pc = call_pc;
        end
        OP_RETURN: begin
          pop = 1'b1;
          retu = 1'b1;
          redir = 1'b1;
        end
        default: ;
      endcase
      if (take) begin
        resolve = (br_depth == '0);
        pop = (br_depth != '0);
        rem_d = br_depth - LBL_W'(1);
        state_d = (br_depth == '0) ? S_RUN : S_UNWIND;
      end
    end
    // one frame is discarded per UNWIND cycle; the last one resolves the target
    if (state_q == S_UNWIND) begin
      pop = (rem_q != '0);
      resolve = (rem_q == '0);
      rem_d = (rem_q != '0) ? rem_q - LBL_W'(1) : rem_q;
      state_d = (rem_q != '0) ? S_UNWIND : S_RUN;
    end
    if (resolve) begin
      pop = (top_f.typ != FT_LOOP);
      redir = 1'b1;
      redir_pc = top_f.extra;
    end
    pc_load_d = redir;
    pc_target_d = redir ? redir_pc : pc_target_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      rem_q <= '0;
      pc_load_q <= 1'b0;
      pc_target_q <= '0;
      prog_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      pc_load_q <= pc_load_d;
      pc_target_q <= pc_target_d;
      prog_done_q <= prog_done_d;
    end
  end
  assign cs_push = push & ~rst;
  assign cs_pop = pop & ~rst;
  assign cs_retu = retu & ~rst;
  assign cs_function_call = fcall & ~rst;
  assign cs_shift_vld = (push | pop) & ~rst;
  assign pc_load = pc_load_q;
  assign pc_target = pc_target_q;
  assign prog_done = prog_done_q;
`ifdef CFS_STATS_EN
  logic [31:0] br_q, br_d, calls_q, calls_d, unw_q, unw_d;
  always_comb begin
    br_d = br_q + {31'b0, accept & take & ~&br_q};
    calls_d = calls_q + {31'b0, fcall & ~rst & ~&calls_q};
    unw_d = unw_q + {31'b0, (state_q == S_UNWIND) & ~&unw_q};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      br_q <= '0;
      calls_q <= '0;
      unw_q <= '0;
    end else begin
      br_q <= br_d;
      calls_q <= calls_d;
      unw_q <= unw_d;
    end
  end
  assign stat_br_taken = br_q;
  assign stat_calls = calls_q;
  assign stat_unwind_cycles = unw_q;
`endif
endmodule

// File: tb/tb_control_flow_sequencer.sv
// tb_control_flow_sequencer: scoreboard bench with a behavioural control stack feeding cs_top_data.
module tb_control_flow_sequencer;
  logic clk, rst, instr_vld, instr_rdy, has_else, cond, blk_retu;
  logic [3:0] instr_op;
  logic [17:0] instr_pc, end_pc, else_pc, call_pc, pc_target;
  logic [7:0] br_depth;
  logic [5:0] sp_tag;
  logic cs_shift_vld, cs_push, cs_pop, cs_retu, cs_function_call, cs_left_one, pc_load, prog_done;
  logic [26:0] cs_push_data, cs_top_data;
`ifdef CFS_STATS_EN
  logic [31:0] st_br, st_calls, st_unw;
`endif
  control_flow_sequencer dut (
    .clk(clk), .rst(rst), .instr_vld(instr_vld), .instr_rdy(instr_rdy), .instr_op(instr_op),
    .instr_pc(instr_pc), .end_pc(end_pc), .else_pc(else_pc), .has_else(has_else), .call_pc(call_pc),
    .br_depth(br_depth), .cond(cond), .blk_retu(blk_retu), .sp_tag(sp_tag),
    .cs_shift_vld(cs_shift_vld), .cs_push(cs_push), .cs_pop(cs_pop), .cs_retu(cs_retu),
    .cs_function_call(cs_function_call), .cs_push_data(cs_push_data), .cs_top_data(cs_top_data),
    .cs_left_one(cs_left_one), .pc_load(pc_load), .pc_target(pc_target), .prog_done(prog_done)
`ifdef CFS_STATS_EN
    , .stat_br_taken(st_br), .stat_calls(st_calls), .stat_unwind_cycles(st_unw)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // behavioural control stack; a return sees (and unwinds through) the innermost call frame
  logic [26:0] stk [64];
  int sp, ret_i;
  always @* begin
    ret_i = 0;
    for (int i = 0; i < 64; i++) if (i < sp && stk[i][26:25] == 2'b01) ret_i = i;
  end
  always @* cs_top_data = (sp == 0) ? '0 : (instr_vld && instr_op == 4'd9) ? stk[ret_i] : stk[sp-1];
  assign cs_left_one = (sp == 1);
  always @(posedge clk) begin
    if (rst) sp <= 0;
    else if (cs_pop) sp <= cs_retu ? ret_i : sp - 1;
    else if (cs_push) begin
      stk[sp] <= cs_push_data;
      sp <= sp + 1;
    end
  end
  int vecs = 0, errs = 0;
  logic [17:0] exp_q [$];
  logic s_push, s_pop, s_retu, s_fc, s_shift;
  logic [26:0] s_data;
  task automatic do_reset();
    rst = 1'b1;
    instr_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask
  task automatic set_ins(input logic [3:0] op, input logic [17:0] pc);
    instr_op = op;
    instr_pc = pc;
  endtask
  task automatic send();
    int n = 0;
    @(negedge clk);
    while (!instr_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_rdy) begin
      vecs++;
      errs++;
      $display("FAIL send_rdy: instr_rdy stuck at 0 for op %0d", instr_op);
    end
    instr_vld = 1'b1;
    #1;
    s_push = cs_push; s_pop = cs_pop; s_retu = cs_retu; s_fc = cs_function_call;
    s_shift = cs_shift_vld; s_data = cs_push_data;
    @(posedge clk);
    #1 instr_vld = 1'b0;
    instr_op = 4'd0;
  endtask
  task automatic wait_redirect(input string nm);
    int n = 0;
    logic [17:0] e;
    @(negedge clk);
    while (!pc_load && n < 8) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 18'h0;
    if (!pc_load) begin
      errs++;
      $display("FAIL %s: pc_load never rose, wanted target %h", nm, e);
    end else if (pc_target !== e) begin
      errs++;
      $display("FAIL %s: pc_target got %h want %h", nm, pc_target, e);
    end
    @(negedge clk);
    vecs++;
    if (pc_load !== 1'b0) begin
      errs++;
      $display("FAIL %s_pulse: pc_load got %b want 0 one cycle later", nm, pc_load);
    end
  endtask
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vecs++;
    if ({instr_rdy, pc_load, pc_target, prog_done, cs_shift_vld, cs_push, cs_pop} !== {1'b1, 1'b0, 18'h0, 4'b0}) begin
      errs++;
      $display("FAIL reset: rdy=%b load=%b tgt=%h done=%b shift=%b want rdy=1 others 0",
               instr_rdy, pc_load, pc_target, prog_done, cs_shift_vld);
    end
  endtask
  task automatic test_call();
    do_reset();
    set_ins(4'd8, 18'h10); call_pc = 18'h40; sp_tag = 6'd5; blk_retu = 1'b1;
    exp_q.push_back(18'h40);
    send();
    vecs++;
    if ({s_push, s_fc, s_shift, s_pop, s_data} !== {4'b1110, 2'b01, 1'b1, 6'd5, 18'h11}) begin
      errs++;
      $display("FAIL call_push: push=%b fc=%b shift=%b pop=%b data=%h want 1110 data=%h",
               s_push, s_fc, s_shift, s_pop, s_data, {2'b01, 1'b1, 6'd5, 18'h11});
    end
    wait_redirect("call_target");
    set_ins(4'd8, 18'h3FFFF); call_pc = 18'h7; sp_tag = 6'd2; blk_retu = 1'b0;
    exp_q.push_back(18'h7);
    send();
    vecs++;
    if (s_data !== {2'b01, 1'b0, 6'd2, 18'h0}) begin
      errs++;
      $display("FAIL call_wrap: data got %h want %h", s_data, {2'b01, 1'b0, 6'd2, 18'h0});
    end
    wait_redirect("call_wrap_target");
  endtask
  task automatic test_br_unwind();
    do_reset();
    blk_retu = 1'b0; sp_tag = 6'd1;
    set_ins(4'd1, 18'h02); end_pc = 18'h30; send();
    set_ins(4'd1, 18'h04); end_pc = 18'h20; send();
    set_ins(4'd2, 18'h18); send();
    vecs++;
    if (s_data !== {2'b11, 1'b0, 6'd1, 18'h19}) begin
      errs++;
      $display("FAIL loop_push: data got %h want %h", s_data, {2'b11, 1'b0, 6'd1, 18'h19});
    end
    set_ins(4'd6, 18'h1A); br_depth = 8'd2;
    exp_q.push_back(18'h30);
    send();
    vecs++;
    if ({s_pop, s_shift, s_push} !== 3'b110) begin
      errs++;
      $display("FAIL br2_c0: pop/shift/push got %b%b%b want 110", s_pop, s_shift, s_push);
    end
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      vecs++;
      if ({cs_pop, instr_rdy} !== 2'b10) begin
        errs++;
        $display("FAIL br2_c%0d: pop=%b rdy=%b want pop=1 rdy=0", c, cs_pop, instr_rdy);
      end
    end
    wait_redirect("br2_target");
    vecs++;
    if (sp !== 0) begin
      errs++;
      $display("FAIL br2_depth: stack depth got %0d want 0", sp);
    end
  endtask
  task automatic test_loop_br0();
    do_reset();
    set_ins(4'd2, 18'h08); send();
    set_ins(4'd7, 18'h0C); br_depth = 8'd0; cond = 1'b1;
    exp_q.push_back(18'h09);
    send();
    vecs++;
    if ({s_shift, s_pop} !== 2'b00) begin
      errs++;
      $display("FAIL br0_noshift: shift=%b pop=%b want 00", s_shift, s_pop);
    end
    wait_redirect("br0_target");
    set_ins(4'd7, 18'h0D); cond = 1'b0; br_depth = 8'd0; send();
    vecs++;
    if ({s_shift, sp} !== {1'b0, 32'd1}) begin
      errs++;
      $display("FAIL brif0: shift=%b depth=%0d want shift 0 depth 1", s_shift, sp);
    end
  endtask
  task automatic test_if_else();
    do_reset();
    set_ins(4'd3, 18'h20); cond = 1'b0; has_else = 1'b1; else_pc = 18'h22; end_pc = 18'h35;
    sp_tag = 6'd3; blk_retu = 1'b1;
    exp_q.push_back(18'h22);
    send();
    vecs++;
    if ({s_push, s_data} !== {1'b1, 2'b10, 1'b1, 6'd3, 18'h35}) begin
      errs++;
      $display("FAIL if_push: push=%b data=%h want 1 %h", s_push, s_data, {2'b10, 1'b1, 6'd3, 18'h35});
    end
    wait_redirect("if_else_target");
    set_ins(4'd4, 18'h28);
    exp_q.push_back(18'h35);
    send();
    vecs++;
    if (s_pop !== 1'b1) begin
      errs++;
      $display("FAIL else_pop: pop got %b want 1", s_pop);
    end
    wait_redirect("else_target");
    set_ins(4'd3, 18'h40); cond = 1'b0; has_else = 1'b0; end_pc = 18'h44;
    exp_q.push_back(18'h44);
    send();
    vecs++;
    if (s_shift !== 1'b0) begin
      errs++;
      $display("FAIL if_noelse: shift got %b want 0", s_shift);
    end
    wait_redirect("if_noelse_target");
  endtask
  task automatic test_return();
    do_reset();
    set_ins(4'd8, 18'h10); call_pc = 18'h40;
    exp_q.push_back(18'h40);
    send();
    wait_redirect("ret_call");
    set_ins(4'd1, 18'h40); end_pc = 18'h60; send();
    set_ins(4'd1, 18'h41); end_pc = 18'h50; send();
    set_ins(4'd9, 18'h42);
    exp_q.push_back(18'h11);
    send();
    vecs++;
    if ({s_pop, s_retu, s_push} !== 3'b110) begin
      errs++;
      $display("FAIL return_strobes: pop/retu/push got %b%b%b want 110", s_pop, s_retu, s_push);
    end
    wait_redirect("return_target");
  endtask
  task automatic test_back_to_back();
    do_reset();
    set_ins(4'd8, 18'h100); call_pc = 18'h200; exp_q.push_back(18'h200); send();
    wait_redirect("b2b_call1");
    set_ins(4'd8, 18'h200); call_pc = 18'h300; exp_q.push_back(18'h300); send();
    wait_redirect("b2b_call2");
    set_ins(4'd1, 18'h300); end_pc = 18'h310; send();
    set_ins(4'd5, 18'h30F); send();
    @(negedge clk);
    vecs++;
    if ({s_pop, pc_load} !== 2'b10) begin
      errs++;
      $display("FAIL end_block: pop=%b pc_load=%b want pop 1 no redirect", s_pop, pc_load);
    end
    set_ins(4'd5, 18'h320);
    exp_q.push_back(18'h201);
    send();
    vecs++;
    if ({s_pop, s_retu, prog_done} !== 3'b100) begin
      errs++;
      $display("FAIL end_call: pop/retu/done got %b%b%b want 100", s_pop, s_retu, prog_done);
    end
    wait_redirect("end_call_target");
  endtask
  task automatic test_end_done();
    do_reset();
    set_ins(4'd8, 18'h3); call_pc = 18'h50; exp_q.push_back(18'h50); send();
    wait_redirect("done_call");
    set_ins(4'd5, 18'h58); send();
    repeat (3) @(negedge clk);
    vecs++;
    if ({s_pop, prog_done, instr_rdy, pc_load} !== 4'b1100) begin
      errs++;
      $display("FAIL done_hold: pop=%b done=%b rdy=%b load=%b want 1100", s_pop, prog_done, instr_rdy, pc_load);
    end
    do_reset();
    @(negedge clk);
    vecs++;
    if ({prog_done, instr_rdy} !== 2'b01) begin
      errs++;
      $display("FAIL done_clear: done=%b rdy=%b want 01", prog_done, instr_rdy);
    end
  endtask
  task automatic test_rst_mid_unwind();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_ins(4'd1, 18'(i)); end_pc = 18'(32'h80 + i); send();
    end
    set_ins(4'd2, 18'h90); send();
    set_ins(4'd6, 18'h91); br_depth = 8'd3; send();
    @(negedge clk);
    rst = 1'b1;
    #1;
    vecs++;
    if ({cs_pop, cs_shift_vld} !== 2'b00) begin
      errs++;
      $display("FAIL rst_unwind_strobe: pop=%b shift=%b want 00", cs_pop, cs_shift_vld);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vecs++;
    if ({instr_rdy, pc_load, cs_pop, cs_shift_vld} !== 4'b1000) begin
      errs++;
      $display("FAIL rst_unwind: rdy=%b load=%b pop=%b shift=%b want 1000", instr_rdy, pc_load, cs_pop, cs_shift_vld);
    end
    @(negedge clk);
    vecs++;
    if ({pc_load, cs_pop} !== 2'b00) begin
      errs++;
      $display("FAIL rst_unwind_after: load=%b pop=%b want 00", pc_load, cs_pop);
    end
  endtask
  initial begin
    rst = 1'b1; instr_vld = 1'b0; instr_op = 4'd0; instr_pc = '0; end_pc = '0; else_pc = '0;
    has_else = 1'b0; call_pc = '0; br_depth = '0; cond = 1'b0; blk_retu = 1'b0; sp_tag = '0;
    test_reset();
    test_call();
    test_br_unwind();
    test_loop_br0();
    test_if_else();
    test_return();
    test_back_to_back();
    test_end_done();
    test_rst_mid_unwind();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
